bp_fe_if_endpoint: RTL and testbench

FE-side endpoint of the FE/BE interface. It is the producer of fe_queue entries and the consumer of fe_cmd entries, the opposite end from the BE top level.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to the BE with valid/ready.
- Decodes BE commands: redirects flush the FIFO and steer the PC generator; fences stall fetch until the I$ reports completion.

---
 rtl/bp_fe_if_endpoint_if.sv | 31 +++
 rtl/bp_fe_if_endpoint.sv | 100 ++++++++++
 tb/tb_bp_fe_if_endpoint.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_if_endpoint_if.sv
// FE/BE endpoint signal bundle: fetch input, fe_queue output, fe_cmd input and I$ controls.
// The master side is the endpoint and the slave side is its environment.
interface bp_fe_if_endpoint_if #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned instr_width_p = 32
);
  logic                                   fetch_v;
  logic [vaddr_width_p-1:0]               fetch_pc;
  logic [instr_width_p-1:0]               fetch_instr;
  logic                                   fetch_ready;
  logic [vaddr_width_p+instr_width_p-1:0] fe_queue;
  logic                                   fe_queue_v;
  logic                                   fe_queue_ready;
  logic [vaddr_width_p+2:0]               fe_cmd;
  logic                                   fe_cmd_v;
  logic                                   fe_cmd_yumi;
  logic                                   redirect_v;
  logic [vaddr_width_p-1:0]               redirect_pc;
  logic                                   fence_v;
  logic                                   fence_done;

  modport master (
    input  fetch_v, fetch_pc, fetch_instr, fe_queue_ready, fe_cmd, fe_cmd_v, fence_done,
    output fetch_ready, fe_queue, fe_queue_v, fe_cmd_yumi, redirect_v, redirect_pc, fence_v
  );

  modport slave (
    output fetch_v, fetch_pc, fetch_instr, fe_queue_ready, fe_cmd, fe_cmd_v, fence_done,
    input  fetch_ready, fe_queue, fe_queue_v, fe_cmd_yumi, redirect_v, redirect_pc, fence_v
  );
endinterface

// File: rtl/bp_fe_if_endpoint.sv
// FE-side endpoint: buffers fetched {pc, instr} in a FIFO for the BE and executes BE
// commands (redirect/flush, I$ fence).
module bp_fe_if_endpoint #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned instr_width_p = 32,
  parameter int unsigned queue_els_p   = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bp_fe_if_endpoint_if.master  bus
);
  localparam int unsigned PtrW   = $clog2(queue_els_p);
  localparam int unsigned CntW   = $clog2(queue_els_p + 1);
  localparam int unsigned EntryW = vaddr_width_p + instr_width_p;

  typedef enum logic [0:0] {e_run, e_fence} state_e;

  state_e                   state_q, state_d;
  logic [EntryW-1:0]        mem_q [queue_els_p];
  logic [PtrW-1:0]          wptr_q, rptr_q;
  logic [CntW-1:0]          count_q;
  logic                     redirect_v_q;
  logic [vaddr_width_p-1:0] redirect_pc_q;

  logic [2:0]               opcode;
  logic [vaddr_width_p-1:0] cmd_vaddr;
  logic                     flush_now, yumi, fetch_ready, queue_v, enq, deq;

  assign opcode    = bus.fe_cmd[vaddr_width_p+2:vaddr_width_p];
  assign cmd_vaddr = bus.fe_cmd[vaddr_width_p-1:0];

  always_comb begin
    state_d   = state_q;
    flush_now = 1'b0;
    yumi      = 1'b0;
    unique case (state_q)
      e_run: begin
        if (bus.fe_cmd_v) begin
          if (opcode == 3'd0 || opcode == 3'd1) begin
            flush_now = 1'b1;
            yumi      = 1'b1;
          end else if (opcode == 3'd2) begin
            state_d = e_fence;
          end else begin
            yumi = 1'b1;
          end
        end
      end
      e_fence: begin
        if (bus.fence_done) begin
          yumi    = bus.fe_cmd_v;
          state_d = e_run;
        end
      end
      default: state_d = e_run;
    endcase
    // Combinational outputs are held low while reset is asserted.
    flush_now = flush_now & reset_i;
    yumi      = yumi & reset_i;
  end

  assign queue_v     = (count_q != '0);
  assign fetch_ready = reset_i & (state_q == e_run) & (count_q != CntW'(queue_els_p)) & ~flush_now;
  assign enq         = bus.fetch_v & fetch_ready;
  assign deq         = queue_v & bus.fe_queue_ready;

  assign bus.fetch_ready = fetch_ready;
  assign bus.fe_queue_v  = queue_v;
  assign bus.fe_queue    = queue_v ? mem_q[rptr_q] : '0;
  assign bus.fe_cmd_yumi = yumi;
  assign bus.redirect_v  = redirect_v_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.fence_v     = (state_q == e_fence);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= e_run;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      redirect_v_q <= flush_now;
      if (flush_now) redirect_pc_q <= cmd_vaddr;
      if (enq) mem_q[wptr_q] <= {bus.fetch_pc, bus.fetch_instr};
      // A flush discards everything, including an entry dequeued this cycle.
      if (flush_now) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (enq) wptr_q <= wptr_q + 1'b1;
        if (deq) rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CntW'(enq) - CntW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_bp_fe_if_endpoint.sv
// Directed testbench for bp_fe_if_endpoint: reset, fill/drain, full concurrency,
// redirect flush, fence, reset mid-fence and ignored opcodes.
module tb_bp_fe_if_endpoint;
  localparam int unsigned VW = 39;
  localparam int unsigned IW = 32;

  logic clk;
  logic reset_n;
  int   n_total = 0;
  int   n_bad   = 0;

  bp_fe_if_endpoint_if #(.vaddr_width_p(VW), .instr_width_p(IW)) bus ();

  bp_fe_if_endpoint #(
    .vaddr_width_p(VW),
    .instr_width_p(IW),
    .queue_els_p  (4)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW+IW-1:0] ent(input logic [VW-1:0] pc, input logic [IW-1:0] ins);
    return {pc, ins};
  endfunction

  task automatic push(input logic [VW-1:0] pc, input logic [IW-1:0] ins);
    bus.fetch_v     = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_instr = ins;
    tick();
    bus.fetch_v = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.fetch_v        = 1'b0;
    bus.fetch_pc       = '0;
    bus.fetch_instr    = '0;
    bus.fe_queue_ready = 1'b0;
    bus.fe_cmd         = '0;
    bus.fe_cmd_v       = 1'b0;
    bus.fence_done     = 1'b0;

    // Reset
    tick(); tick(); tick();
    check_eq("rst_fetch_ready", bus.fetch_ready, 0);
    check_eq("rst_queue_v", bus.fe_queue_v, 0);
    check_eq("rst_yumi", bus.fe_cmd_yumi, 0);
    check_eq("rst_redirect_v", bus.redirect_v, 0);
    check_eq("rst_fence_v", bus.fence_v, 0);
    check_eq("rst_fe_queue", bus.fe_queue, 0);
    check_eq("rst_redirect_pc", bus.redirect_pc, 0);
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_fetch_ready", bus.fetch_ready, 1);
    check_eq("post_rst_queue_v", bus.fe_queue_v, 0);

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_ready", bus.fetch_ready, 1);
      if (i > 0) check_eq("fill_v", bus.fe_queue_v, 1);
      push(39'h1000 + 39'(4 * i), 32'h100 + 32'(i));
    end
    check_eq("full_ready", bus.fetch_ready, 0);
    check_eq("full_head", bus.fe_queue, ent(39'h1000, 32'h100));
    bus.fe_queue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("drain_v", bus.fe_queue_v, 1);
      check_eq("drain_head", bus.fe_queue, ent(39'h1000 + 39'(4 * i), 32'h100 + 32'(i)));
      tick();
    end
    check_eq("drained_v", bus.fe_queue_v, 0);
    bus.fe_queue_ready = 1'b0;

    // Concurrent enqueue/dequeue at full
    for (int i = 0; i < 4; i++) push(39'h2000 + 39'(4 * i), 32'h200 + 32'(i));
    bus.fetch_v        = 1'b1;
    bus.fetch_pc       = 39'h2010;
    bus.fetch_instr    = 32'h204;
    bus.fe_queue_ready = 1'b1;
    #1;
    check_eq("cf_ready_full", bus.fetch_ready, 0);
    check_eq("cf_head0", bus.fe_queue, ent(39'h2000, 32'h200));
    tick();
    check_eq("cf_ready_3", bus.fetch_ready, 1);
    check_eq("cf_head1", bus.fe_queue, ent(39'h2004, 32'h201));
    tick();
    bus.fetch_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("cf_drain_v", bus.fe_queue_v, 1);
      check_eq("cf_drain_head", bus.fe_queue, ent(39'h2008 + 39'(4 * i), 32'h202 + 32'(i)));
      tick();
    end
    check_eq("cf_empty", bus.fe_queue_v, 0);
    bus.fe_queue_ready = 1'b0;

    // Redirect flush with concurrent dequeue and fetch
    for (int i = 0; i < 3; i++) push(39'h3000 + 39'(4 * i), 32'h300 + 32'(i));
    bus.fetch_v        = 1'b1;
    bus.fetch_pc       = 39'h300C;
    bus.fetch_instr    = 32'h303;
    bus.fe_queue_ready = 1'b1;
    bus.fe_cmd         = {3'd1, 39'h8000_0000};
    bus.fe_cmd_v       = 1'b1;
    #1;
    check_eq("rd_yumi", bus.fe_cmd_yumi, 1);
    check_eq("rd_fetch_ready", bus.fetch_ready, 0);
    check_eq("rd_head", bus.fe_queue, ent(39'h3000, 32'h300));
    tick();
    bus.fe_cmd_v = 1'b0;
    bus.fetch_v  = 1'b0;
    #1;
    check_eq("rd_flushed", bus.fe_queue_v, 0);
    check_eq("rd_redirect_v", bus.redirect_v, 1);
    check_eq("rd_redirect_pc", bus.redirect_pc, 39'h8000_0000);
    tick();
    check_eq("rd_pulse_end", bus.redirect_v, 0);
    check_eq("rd_still_empty", bus.fe_queue_v, 0);
    bus.fe_queue_ready = 1'b0;

    // Fence
    bus.fe_cmd   = {3'd2, 39'h0};
    bus.fe_cmd_v = 1'b1;
    #1;
    check_eq("fc_no_yumi0", bus.fe_cmd_yumi, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("fc_fence_v", bus.fence_v, 1);
      check_eq("fc_fetch_ready", bus.fetch_ready, 0);
      check_eq("fc_no_yumi", bus.fe_cmd_yumi, 0);
      tick();
    end
    bus.fence_done = 1'b1;
    #1;
    check_eq("fc_yumi", bus.fe_cmd_yumi, 1);
    tick();
    bus.fence_done = 1'b0;
    bus.fe_cmd_v   = 1'b0;
    #1;
    check_eq("fc_fence_off", bus.fence_v, 0);
    check_eq("fc_ready_back", bus.fetch_ready, 1);

    // fence_done while running is ignored
    bus.fence_done = 1'b1;
    tick();
    bus.fence_done = 1'b0;
    check_eq("fd_idle_fence_v", bus.fence_v, 0);

    // Reset mid-fence
    push(39'h5000, 32'h500);
    bus.fe_cmd   = {3'd2, 39'h0};
    bus.fe_cmd_v = 1'b1;
    tick(); tick();
    check_eq("rf_in_fence", bus.fence_v, 1);
    bus.fe_cmd_v = 1'b0;
    reset_n      = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rf_fence_off", bus.fence_v, 0);
    check_eq("rf_empty", bus.fe_queue_v, 0);

    // Ignored opcode
    push(39'h6000, 32'h600);
    bus.fe_cmd   = {3'd5, 39'h1234};
    bus.fe_cmd_v = 1'b1;
    #1;
    check_eq("op5_yumi", bus.fe_cmd_yumi, 1);
    check_eq("op5_fetch_ready", bus.fetch_ready, 1);
    tick();
    bus.fe_cmd_v = 1'b0;
    #1;
    check_eq("op5_no_redirect", bus.redirect_v, 0);
    check_eq("op5_queue_v", bus.fe_queue_v, 1);
    check_eq("op5_head", bus.fe_queue, ent(39'h6000, 32'h600));
    bus.fe_queue_ready = 1'b1;
    tick();
    check_eq("op5_one_entry", bus.fe_queue_v, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
